dmem_arbiter: RTL and testbench

Shares the single-port data memory between the processor load/store path and a secondary requester (program/data loader or debug port). It runs one request per cycle, with round-robin fairness and a bounded burst lock for the loader, and routes read data back to the issuing requester after the fixed memory read latency. It sits between the processor's dmem port and the dmem instance, replacing the direct processor-to-dmem connection.

---
 rtl/dmem_arb_pkg.sv | 25 ++
 rtl/dmem_arb_tagpipe.sv | 42 ++++
 rtl/dmem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - Default address and data widths of the dmem port.
//   - Owner encoding that tags every issued read (processor or loader).
//   - Lock-state enum for the loader burst lock.
//   - Read tag carried through the read-latency pipeline.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    // Owner encoding. It is also used for the last_win register.
    localparam logic OWN_PROC = 1'b0;
    localparam logic OWN_LOAD = 1'b1;

    typedef enum logic {
        LOCK_UNLOCKED = 1'b0,
        LOCK_LOCKED   = 1'b1
    } lock_state_t;

    typedef struct packed {
        logic valid;
        logic owner;
    } read_tag_t;

endpackage

// File: rtl/dmem_arb_tagpipe.sv
// Read-tag delay line for the data-memory arbiter.
// A {valid, owner} tag enters on every issue cycle. It leaves DEPTH cycles
// later, aligned with the dmem read data for that issue.
//   clk     : clock
//   srst    : synchronous active-high clear; drops every in-flight tag
//   tag_in  : tag of the request issued this cycle (valid=0 for writes/idle)
//   tag_out : tag whose read data is on q_dmem this cycle
module dmem_arb_tagpipe
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic      clk,
    input  logic      srst,
    input  read_tag_t tag_in,
    output read_tag_t tag_out
);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            read_tag_t stage_reg;
            read_tag_t stage_next;

            if (gi == 0) begin : g_head
                assign stage_next = tag_in;
            end else begin : g_body
                assign stage_next = g_stage[gi-1].stage_reg;
            end

            always_ff @(posedge clk) begin
                if (srst) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= stage_next;
                end
            end
        end
    endgenerate

    assign tag_out = g_stage[DEPTH-1].stage_reg;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the processor load/store path and a
// secondary requester (the loader or debug port).
// At most one request is issued per cycle. Arbitration is round-robin on a
// tie. The loader can hold the memory for a bounded burst with l_lock, up
// to MAX_BURST grants while the processor waits. Read data returns to the
// issuing side READ_LATENCY cycles after the grant.
//   clock, reset                       : clock, synchronous active-high reset
//   p_req/p_wren/p_addr/p_wdata        : processor request (held until p_gnt)
//   p_gnt/p_rvalid/p_rdata             : processor grant and read return
//   l_req/l_wren/l_addr/l_wdata/l_lock : loader request plus burst lock
//   l_gnt/l_rvalid/l_rdata             : loader grant and read return
//   address_dmem/data/wren/q_dmem      : single-port dmem interface
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int READ_LATENCY = 1,
    parameter int MAX_BURST    = 8
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              p_req,
    input  logic              p_wren,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,

    input  logic              l_req,
    input  logic              l_wren,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic              l_lock,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,

    output logic [ADDR_W-1:0] address_dmem,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q_dmem
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    lock_state_t      lock_state_reg, lock_state_next;
    logic             last_win_reg, last_win_next;
    logic [CNT_W-1:0] burst_cnt_reg, burst_cnt_next;
    logic [DATA_W-1:0] p_rdata_reg, l_rdata_reg;

    logic      lock_active;
    logic      burst_full;
    logic      contend;
    logic      forced_release;
    logic      p_win, l_win;
    read_tag_t tag_in, tag_out;
    logic      p_ret, l_ret;

    assign lock_active    = (lock_state_reg == LOCK_LOCKED);
    assign burst_full     = (burst_cnt_reg == CNT_W'(MAX_BURST));
    assign contend        = p_req & l_req;
    // The waiting processor takes the slot once the loader's burst budget
    // is used up, and the lock is dropped.
    assign forced_release = contend & lock_active & burst_full;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            lock_state_reg <= LOCK_UNLOCKED;
            last_win_reg   <= OWN_LOAD;   // the processor wins the first tie
            burst_cnt_reg  <= '0;
            p_rdata_reg    <= '0;
            l_rdata_reg    <= '0;
        end else begin
            lock_state_reg <= lock_state_next;
            last_win_reg   <= last_win_next;
            burst_cnt_reg  <= burst_cnt_next;
            if (p_ret) begin
                p_rdata_reg <= q_dmem;
            end
            if (l_ret) begin
                l_rdata_reg <= q_dmem;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: lock FSM, round-robin pointer, burst counter
    // ------------------------------------------------------------------
    always_comb begin
        lock_state_next = lock_state_reg;
        case (lock_state_reg)
            LOCK_UNLOCKED: begin
                if (l_win && l_lock) begin
                    lock_state_next = LOCK_LOCKED;
                end
            end
            LOCK_LOCKED: begin
                if (forced_release || !l_req || (l_win && !l_lock)) begin
                    lock_state_next = LOCK_UNLOCKED;
                end
            end
            default: lock_state_next = LOCK_UNLOCKED;
        endcase
    end

    always_comb begin
        last_win_next = last_win_reg;
        if (p_win) begin
            last_win_next = OWN_PROC;
        end else if (l_win) begin
            last_win_next = OWN_LOAD;
        end
    end

    // The grant that takes the lock counts toward the burst. So MAX_BURST
    // is the total number of locked loader grants the processor sits through.
    always_comb begin
        burst_cnt_next = burst_cnt_reg;
        if (lock_state_next == LOCK_UNLOCKED || !p_req) begin
            burst_cnt_next = '0;
        end else if (l_win && !burst_full) begin
            burst_cnt_next = burst_cnt_reg + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output logic: grant, dmem mux, read return
    // ------------------------------------------------------------------
    always_comb begin
        p_win = 1'b0;
        l_win = 1'b0;
        if (!reset) begin
            if (contend) begin
                if (lock_active) begin
                    l_win = !burst_full;
                end else begin
                    l_win = (last_win_reg == OWN_PROC);
                end
                p_win = !l_win;
            end else begin
                p_win = p_req;
                l_win = l_req;
            end
        end
    end

    assign p_gnt = p_win;
    assign l_gnt = l_win;

    always_comb begin
        wren         = 1'b0;
        address_dmem = '0;
        data         = '0;
        if (p_win) begin
            wren         = p_wren;
            address_dmem = p_addr;
            data         = p_wdata;
        end else if (l_win) begin
            wren         = l_wren;
            address_dmem = l_addr;
            data         = l_wdata;
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = (p_win & ~p_wren) | (l_win & ~l_wren);
        tag_in.owner = l_win ? OWN_LOAD : OWN_PROC;
    end

    dmem_arb_tagpipe #(
        .DEPTH (READ_LATENCY)
    ) u_tagpipe (
        .clk     (clock),
        .srst    (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Reset is gated in here as well. A read whose data lands in the reset
    // cycle itself then never shows as valid.
    assign p_ret = !reset && tag_out.valid && (tag_out.owner == OWN_PROC);
    assign l_ret = !reset && tag_out.valid && (tag_out.owner == OWN_LOAD);

    assign p_rvalid = p_ret;
    assign l_rvalid = l_ret;
    assign p_rdata  = reset ? '0 : (p_ret ? q_dmem : p_rdata_reg);
    assign l_rdata  = reset ? '0 : (l_ret ? q_dmem : l_rdata_reg);

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int RL = 2;
    localparam int MB = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          p_req, p_wren, l_req, l_wren, l_lock;
    logic [AW-1:0] p_addr, l_addr;
    logic [DW-1:0] p_wdata, l_wdata;
    logic          p_gnt, p_rvalid, l_gnt, l_rvalid, wren;
    logic [DW-1:0] p_rdata, l_rdata, data, q_dmem;
    logic [AW-1:0] address_dmem;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .MAX_BURST(MB)
    ) dut (
        .clock(clk), .reset(reset),
        .p_req(p_req), .p_wren(p_wren), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .l_req(l_req), .l_wren(l_wren), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
    );

    // Initial memory contents (known words at 0x004 for the processor test)
    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 'h004) return 32'h0000BEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // dmem: single port, read data READ_LATENCY cycles after the address
    logic [DW-1:0] mem [0:4095];
    logic [DW-1:0] rd_pipe [RL];
    bit mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (wren) begin
            mem[address_dmem] <= data;
        end
        rd_pipe[0] <= mem[address_dmem];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign q_dmem = rd_pipe[RL-1];

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        bit            owner;
        logic [DW-1:0] val;
    } rd_t;
    rd_t           rq[$];
    logic [DW-1:0] shadow [0:4095];
    bit            m_last_win, m_locked;
    int            m_burst;
    logic [DW-1:0] m_prd, m_lrd;

    logic          e_pg, e_lg, e_prv, e_lrv, e_wren;
    logic [DW-1:0] e_prd, e_lrd, e_data;
    logic [AW-1:0] e_addr;
    logic          o_pg, o_lg, o_prv, o_lrv, o_wren;
    logic [DW-1:0] o_prd, o_lrd, o_data;
    logic [AW-1:0] o_addr;

    // One clock cycle: sample the DUT mid-cycle, predict from the rules,
    // advance the model, then move to just after the next rising edge.
    task automatic tick();
        rd_t r;
        bit  forced;
        @(negedge clk);
        o_pg = p_gnt; o_lg = l_gnt; o_prv = p_rvalid; o_lrv = l_rvalid;
        o_prd = p_rdata; o_lrd = l_rdata; o_wren = wren; o_addr = address_dmem; o_data = data;
        e_pg = 1'b0; e_lg = 1'b0;
        if (!reset) begin
            if (p_req && l_req) begin
                if (m_locked) begin
                    if (m_burst == MB) e_pg = 1'b1; else e_lg = 1'b1;
                end else if (m_last_win) e_pg = 1'b1;
                else e_lg = 1'b1;
            end else begin
                e_pg = p_req; e_lg = l_req;
            end
        end
        e_wren = 1'b0; e_addr = '0; e_data = '0;
        if (e_pg) begin e_wren = p_wren; e_addr = p_addr; e_data = p_wdata; end
        else if (e_lg) begin e_wren = l_wren; e_addr = l_addr; e_data = l_wdata; end
        e_prv = 1'b0; e_lrv = 1'b0;
        if (reset) begin
            rq.delete(); m_prd = '0; m_lrd = '0;
        end else if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            if (r.owner) begin e_lrv = 1'b1; m_lrd = r.val; end
            else begin e_prv = 1'b1; m_prd = r.val; end
        end
        e_prd = m_prd; e_lrd = m_lrd;
        if (reset) begin
            m_last_win = 1'b1; m_locked = 1'b0; m_burst = 0;
        end else begin
            forced = p_req && l_req && m_locked && (m_burst == MB);
            if (e_pg || e_lg) begin
                if (e_wren) shadow[e_addr] = e_data;
                else rq.push_back('{due: cyc + RL, owner: e_lg, val: shadow[e_addr]});
                m_last_win = e_lg;
            end
            if (!m_locked) m_locked = e_lg && l_lock;
            else if (forced || !l_req || (e_lg && !l_lock)) m_locked = 1'b0;
            if (!m_locked || !p_req) m_burst = 0;
            else if (e_lg && m_burst < MB) m_burst++;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle();
        p_req = 0; p_wren = 0; p_addr = '0; p_wdata = '0;
        l_req = 0; l_wren = 0; l_addr = '0; l_wdata = '0; l_lock = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1; idle();
        p_req = 1; l_req = 1; l_wren = 1; l_addr = 12'h123; p_addr = 12'h321;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (o_pg !== 1'b0 || o_lg !== 1'b0 || o_wren !== 1'b0) begin
                failures++;
                $display("FAIL reset_gnt: p_gnt=%b l_gnt=%b wren=%b required 0 0 0", o_pg, o_lg, o_wren);
            end
        end
        reset = 0; idle();
        tick();
        checks++;
        if ({o_prv, o_lrv, o_prd, o_lrd, o_wren, o_addr, o_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: rv=%b/%b rd=%h/%h wren=%b addr=%h data=%h required all 0",
                     o_prv, o_lrv, o_prd, o_lrd, o_wren, o_addr, o_data);
        end
    endtask

    task automatic test_proc_only();
        idle(); p_req = 1; p_addr = 12'h004;
        tick();
        checks++;
        if (o_pg !== 1'b1 || o_lg !== 1'b0) begin
            failures++; $display("FAIL proc_only_gnt: p_gnt=%b l_gnt=%b required 1 0", o_pg, o_lg);
        end
        idle();
        for (int i = 1; i <= RL; i++) begin
            tick();
            checks++;
            if (o_lrv !== 1'b0) begin
                failures++; $display("FAIL proc_only_lrv: l_rvalid=%b required 0", o_lrv);
            end
            checks++;
            if (o_prv !== (i == RL) || (i == RL && o_prd !== 32'h0000BEEF)) begin
                failures++;
                $display("FAIL proc_only_read: cycle +%0d p_rvalid=%b p_rdata=%h required %b 0000beef",
                         i, o_prv, o_prd, (i == RL));
            end
        end
    endtask

    task automatic test_alternate();
        idle(); reset = 1; tick(); reset = 0;
        p_req = 1; l_req = 1;
        for (int i = 0; i < 8; i++) begin
            p_addr = AW'($urandom_range(0, 4095)); l_addr = AW'($urandom_range(0, 4095));
            tick();
            checks++;
            if (o_pg !== (i % 2 == 0) || o_lg !== (i % 2 != 0)) begin
                failures++;
                $display("FAIL alternate_gnt: step %0d p_gnt=%b l_gnt=%b required %b %b",
                         i, o_pg, o_lg, (i % 2 == 0), (i % 2 != 0));
            end
            checks++;
            if (o_prv !== e_prv || o_lrv !== e_lrv || o_prd !== e_prd || o_lrd !== e_lrd) begin
                failures++;
                $display("FAIL alternate_ret: rv=%b/%b rd=%h/%h required %b/%b %h/%h",
                         o_prv, o_lrv, o_prd, o_lrd, e_prv, e_lrv, e_prd, e_lrd);
            end
        end
        idle();
        for (int i = 0; i < RL; i++) tick();
    endtask

    task automatic test_burst();
        logic [DW-1:0] vals [12];
        int lk = 0, idx = 0, nret = 0;
        for (int k = 0; k < 12; k++) vals[k] = $urandom;
        idle(); reset = 1; tick(); reset = 0;
        p_req = 1; p_addr = 12'h040; tick();   // processor becomes last winner
        p_addr = AW'($urandom_range('h200, 'h2FF));
        l_req = 1; l_wren = 1; l_lock = 1; l_addr = 12'h100; l_wdata = vals[0];
        while (lk < 12 && idx < 40) begin
            tick();
            checks++;
            if (o_lg !== (idx != 8) || o_pg !== (idx == 8)) begin
                failures++;
                $display("FAIL burst_seq: grant %0d p_gnt=%b l_gnt=%b required %b %b",
                         idx, o_pg, o_lg, (idx == 8), (idx != 8));
            end
            checks++;
            if (o_wren !== e_wren || o_addr !== e_addr || o_data !== e_data) begin
                failures++;
                $display("FAIL burst_bus: wren=%b addr=%h data=%h required %b %h %h",
                         o_wren, o_addr, o_data, e_wren, e_addr, e_data);
            end
            idx++;
            if (o_lg === 1'b1) begin
                lk++;
                if (lk < 12) begin l_addr = AW'('h100 + lk); l_wdata = vals[lk]; end
                else l_req = 0;
            end
            if (o_pg === 1'b1) p_addr = AW'($urandom_range('h200, 'h2FF));
        end
        checks++;
        if (lk != 12) begin
            failures++; $display("FAIL burst_timeout: loader writes=%0d required 12", lk);
        end
        idle();
        for (int i = 0; i < RL; i++) tick();
        for (int k = 0; k < 12 + RL; k++) begin
            idle();
            if (k < 12) begin p_req = 1; p_addr = AW'('h100 + k); end
            tick();
            if (o_prv === 1'b1) begin
                checks++;
                if (nret > 11 || o_prd !== vals[nret]) begin
                    failures++;
                    $display("FAIL burst_readback: word %0d p_rdata=%h required %h",
                             nret, o_prd, vals[nret % 12]);
                end
                nret++;
            end
        end
        checks++;
        if (nret != 12) begin
            failures++; $display("FAIL burst_readback_count: returns=%0d required 12", nret);
        end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j <= RL + 1; j++) begin
            idle();
            if (j == 0) begin p_req = 1; p_addr = 12'h010; end
            if (j == 1) begin l_req = 1; l_addr = 12'h020; end
            tick();
            if (j < 2) begin
                checks++;
                if (o_pg !== (j == 0) || o_lg !== (j == 1)) begin
                    failures++;
                    $display("FAIL b2b_gnt: step %0d p_gnt=%b l_gnt=%b", j, o_pg, o_lg);
                end
            end
            checks++;
            if (o_prv !== (j == RL) || (j == RL && o_prd !== init_val('h010))) begin
                failures++;
                $display("FAIL b2b_p: step %0d p_rvalid=%b p_rdata=%h required %b %h",
                         j, o_prv, o_prd, (j == RL), init_val('h010));
            end
            checks++;
            if (o_lrv !== (j == RL + 1) || (j == RL + 1 && o_lrd !== init_val('h020))) begin
                failures++;
                $display("FAIL b2b_l: step %0d l_rvalid=%b l_rdata=%h required %b %h",
                         j, o_lrv, o_lrd, (j == RL + 1), init_val('h020));
            end
        end
    endtask

    task automatic test_write_read();
        idle(); l_req = 1; l_wren = 1; l_addr = 12'h0FF; l_wdata = 32'hCAFEF00D;
        tick();
        checks++;
        if (o_lg !== 1'b1 || o_wren !== 1'b1 || o_addr !== 12'h0FF || o_data !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL wr_issue: l_gnt=%b wren=%b addr=%h data=%h required 1 1 0ff cafef00d",
                     o_lg, o_wren, o_addr, o_data);
        end
        idle(); p_req = 1; p_addr = 12'h0FF;
        tick();
        idle();
        for (int i = 1; i <= RL; i++) tick();
        checks++;
        if (o_prv !== 1'b1 || o_prd !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL wr_then_rd: p_rvalid=%b p_rdata=%h required 1 cafef00d", o_prv, o_prd);
        end
    endtask

    task automatic test_reset_midread();
        idle(); p_req = 1; p_addr = 12'h004;
        tick();
        idle(); reset = 1;
        tick();
        reset = 0;
        tick();
        checks++;
        if ({o_pg, o_lg, o_prv, o_lrv, o_prd, o_lrd, o_wren, o_addr, o_data} !== '0) begin
            failures++;
            $display("FAIL midread_outputs: rv=%b/%b rd=%h/%h wren=%b required all 0",
                     o_prv, o_lrv, o_prd, o_lrd, o_wren);
        end
        for (int i = 0; i < RL; i++) begin
            tick();
            checks++;
            if (o_prv !== 1'b0 || o_lrv !== 1'b0) begin
                failures++;
                $display("FAIL midread_rvalid: p_rvalid=%b l_rvalid=%b required 0 0", o_prv, o_lrv);
            end
        end
        p_req = 1; l_req = 1; p_addr = 12'h033; l_addr = 12'h044;
        tick();
        checks++;
        if (o_pg !== 1'b1 || o_lg !== 1'b0) begin
            failures++;
            $display("FAIL first_tie: p_gnt=%b l_gnt=%b required 1 0", o_pg, o_lg);
        end
        idle();
        for (int i = 0; i < RL + 1; i++) tick();
    endtask

    task automatic test_random();
        bit p_pend = 0, l_pend = 0;
        idle();
        for (int i = 0; i < 400 + RL + 1; i++) begin
            if (i < 400) begin
                if (!p_pend && $urandom_range(0, 99) < 70) begin
                    p_pend = 1; p_wren = 1'($urandom_range(0, 1));
                    p_addr = AW'($urandom_range(0, 31)); p_wdata = $urandom;
                end
                if (!l_pend && $urandom_range(0, 99) < 70) begin
                    l_pend = 1; l_wren = 1'($urandom_range(0, 1));
                    l_addr = AW'($urandom_range(0, 31)); l_wdata = $urandom;
                end
                l_lock = ($urandom_range(0, 7) != 0);
            end else begin
                p_pend = 0; l_pend = 0;
            end
            p_req = p_pend; l_req = l_pend;
            tick();
            checks++;
            if (o_pg !== e_pg || o_lg !== e_lg) begin
                failures++;
                $display("FAIL rand_gnt: cycle %0d p_gnt=%b l_gnt=%b required %b %b", i, o_pg, o_lg, e_pg, e_lg);
            end
            checks++;
            if (o_wren !== e_wren || o_addr !== e_addr || o_data !== e_data) begin
                failures++;
                $display("FAIL rand_bus: cycle %0d wren=%b addr=%h data=%h required %b %h %h",
                         i, o_wren, o_addr, o_data, e_wren, e_addr, e_data);
            end
            checks++;
            if (o_prv !== e_prv || o_prd !== e_prd) begin
                failures++;
                $display("FAIL rand_p_ret: cycle %0d p_rvalid=%b p_rdata=%h required %b %h",
                         i, o_prv, o_prd, e_prv, e_prd);
            end
            checks++;
            if (o_lrv !== e_lrv || o_lrd !== e_lrd) begin
                failures++;
                $display("FAIL rand_l_ret: cycle %0d l_rvalid=%b l_rdata=%h required %b %h",
                         i, o_lrv, o_lrd, e_lrv, e_lrd);
            end
            if (o_pg === 1'b1) p_pend = 0;
            if (o_lg === 1'b1) l_pend = 0;
        end
    endtask

    initial begin
        reset = 1;
        idle();
        for (int i = 0; i < 4096; i++) shadow[i] = init_val(i);
        test_reset();
        test_proc_only();
        test_alternate();
        test_burst();
        test_back_to_back();
        test_write_read();
        test_reset_midread();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
